instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have ports opcode  in  3  and op  in  2, carrying instruction-register fields IR[15:13] and IR[12:11].
REQ-004 SHALL have port mem_rdy  in  1  memory handshake; 1 = current read data valid / write accepted.
REQ-005 SHALL have outputs reset_pc, load_pc, load_ir, load_addr, addr_sel  out  1 each  fetch/address controls; addr_sel=1 selects PC, 0 selects data address.
REQ-006 SHALL have output mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE.
REQ-007 SHALL have outputs vsel  out  4  writeback mux one-hot (0001 C, 0100 sximm8, 1000 mdata) and nsel  out  3  register select one-hot (100 Rn, 010 Rd, 001 Rm).
REQ-008 SHALL have outputs write, loada, loadb, asel, bsel, loadc, loads  out  1 each  datapath controls; asel=1 zeroes A, bsel=1 selects sximm5.
REQ-009 SHALL have output halted  out  1  1 while in HALT.

Function
REQ-010 SHALL be a Moore FSM; every control output not listed for a state SHALL be 0 (vsel/nsel 0, mem_cmd NONE).
REQ-011 RST: reset_pc=1, load_pc=1; next IF1.
REQ-012 IF1: addr_sel=1, mem_cmd=READ; remain while mem_rdy=0, go IF2 when mem_rdy=1.
REQ-013 IF2: addr_sel=1, mem_cmd=READ, load_ir=1; next UPC. UPC: load_pc=1; next DECODE. DECODE: no controls; branch per REQ-014..019.
REQ-014 MOV imm (110/10): MI nsel=100, vsel=0100, write=1; next IF1 (3+ fetch cycles + 2).
REQ-015 MOV reg (110/00): MR1 nsel=001 loadb; MR2 asel=1 loadc; MR3 nsel=010 vsel=0001 write; next IF1.
REQ-016 ALU (101/xx): GA nsel=100 loada; GB nsel=001 loadb; EX loadc=1 except op=01 (CMP) where loadc=0 and loads=1; CMP then IF1, others WB nsel=010 vsel=0001 write, then IF1.
REQ-017 LDR (011/00): LA nsel=100 loada; LB bsel=1 loadc; LC load_addr; LM addr_sel=0 mem_cmd=READ, hold until mem_rdy=1; LW addr_sel=0 mem_cmd=READ nsel=010 vsel=1000 write; next IF1.
REQ-018 STR (100/00): SA nsel=100 loada; SB bsel=1 loadc; SC load_addr; SD nsel=010 loadb; SE asel=1 loadc; SF addr_sel=0 mem_cmd=WRITE, hold until mem_rdy=1; next IF1.
REQ-019 Any other opcode/op combination (including 111 when REQ-024 disabled) SHALL behave as NOP: DECODE -> IF1.
REQ-020 mem_cmd SHALL remain stable for the entire duration of a wait in IF1, LM, SF; mem_rdy outside those states SHALL be ignored.
REQ-021 opcode/op SHALL be sampled only in DECODE; changes elsewhere have no effect.

Reset
REQ-022 reset=0 at any clock edge, including mid-instruction or mid-wait, SHALL force state RST next cycle; outputs follow RST values; an in-flight memory command SHALL be dropped.
REQ-023 With reset held 0, FSM SHALL stay in RST (reset_pc=load_pc=1, halted=0); first cycle after release SHALL be RST, then IF1.

Configuration
REQ-024 Macro SEQ_HALT_EN: when defined, opcode 111 in DECODE SHALL enter HALT (halted=1, all other controls 0, mem_cmd NONE), remaining there until reset=0; when undefined, HALT state SHALL not exist, opcode 111 is NOP per REQ-019, halted tied 0.

Verification
REQ-025 reset=0 2 cycles, release, mem_rdy=1 -> states RST,IF1,IF2,UPC,DECODE; reset_pc=1 only in RST cycles; load_ir=1 exactly one cycle.
REQ-026 IR MOV R0,#7 (opcode 110, op 10), mem_rdy=1 -> exactly one write cycle with nsel=100, vsel=0100; next cycle mem_cmd=READ addr_sel=1.
REQ-027 IR CMP (101/01) -> loads=1 one cycle, loadc never 1, write never 1 during instruction.
REQ-028 LDR with mem_rdy=0 for 3 cycles in LM -> LM held 4 cycles, mem_cmd=READ addr_sel=0 throughout, then one write cycle with vsel=1000, nsel=010.
REQ-029 STR, then reset=0 during SF -> next cycle RST, mem_cmd=NONE, no further WRITE issued.
REQ-030 opcode 111: with SEQ_HALT_EN -> halted=1 held 10+ cycles, mem_cmd NONE; without -> returns to IF1, halted=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Moore control sequencer: fetch, decode and execute of MOV/ALU/LDR/STR.
// Optional HALT state for opcode 111 is built when SEQ_HALT_EN is defined.
module instr_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic       mem_rdy,
    output logic       reset_pc,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
    output logic [3:0] vsel,
    output logic [2:0] nsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic       halted
);

    localparam logic [4:0] S_RST  = 5'd0;
    localparam logic [4:0] S_IF1  = 5'd1;
    localparam logic [4:0] S_IF2  = 5'd2;
    localparam logic [4:0] S_UPC  = 5'd3;
    localparam logic [4:0] S_DEC  = 5'd4;
    localparam logic [4:0] S_MI   = 5'd5;
    localparam logic [4:0] S_MR1  = 5'd6;
    localparam logic [4:0] S_MR2  = 5'd7;
    localparam logic [4:0] S_MR3  = 5'd8;
    localparam logic [4:0] S_GA   = 5'd9;
    localparam logic [4:0] S_GB   = 5'd10;
    localparam logic [4:0] S_EX   = 5'd11;
    localparam logic [4:0] S_CMP  = 5'd12;
    localparam logic [4:0] S_WB   = 5'd13;
    localparam logic [4:0] S_LA   = 5'd14;
    localparam logic [4:0] S_LB   = 5'd15;
    localparam logic [4:0] S_LC   = 5'd16;
    localparam logic [4:0] S_LM   = 5'd17;
    localparam logic [4:0] S_LW   = 5'd18;
    localparam logic [4:0] S_SA   = 5'd19;
    localparam logic [4:0] S_SB   = 5'd20;
    localparam logic [4:0] S_SC   = 5'd21;
    localparam logic [4:0] S_SD   = 5'd22;
    localparam logic [4:0] S_SE   = 5'd23;
    localparam logic [4:0] S_SF   = 5'd24;
`ifdef SEQ_HALT_EN
    localparam logic [4:0] S_HALT = 5'd25;
`endif

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam logic [3:0] V_C   = 4'b0001;
    localparam logic [3:0] V_IMM = 4'b0100;
    localparam logic [3:0] V_MEM = 4'b1000;

    localparam logic [2:0] N_RN = 3'b100;
    localparam logic [2:0] N_RD = 3'b010;
    localparam logic [2:0] N_RM = 3'b001;

    logic [4:0] state_q;
    logic [4:0] state_d;
    logic       cmp_q;
    logic       cmp_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RST;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmp_q   <= cmp_d;
        end
    end

    // The CMP flavour is captured in DECODE so later op changes are ignored.
    always_comb begin
        cmp_d = cmp_q;
        if (state_q == S_DEC) begin
            cmp_d = (op == 2'b01);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST: state_d = S_IF1;
            S_IF1: state_d = mem_rdy ? S_IF2 : S_IF1;
            S_IF2: state_d = S_UPC;
            S_UPC: state_d = S_DEC;
            S_DEC: begin
                state_d = S_IF1;
                if (opcode == 3'b110 && op == 2'b10) begin
                    state_d = S_MI;
                end else if (opcode == 3'b110 && op == 2'b00) begin
                    state_d = S_MR1;
                end else if (opcode == 3'b101) begin
                    state_d = S_GA;
                end else if (opcode == 3'b011 && op == 2'b00) begin
                    state_d = S_LA;
                end else if (opcode == 3'b100 && op == 2'b00) begin
                    state_d = S_SA;
`ifdef SEQ_HALT_EN
                end else if (opcode == 3'b111) begin
                    state_d = S_HALT;
`endif
                end
            end
            S_MI:  state_d = S_IF1;
            S_MR1: state_d = S_MR2;
            S_MR2: state_d = S_MR3;
            S_MR3: state_d = S_IF1;
            S_GA:  state_d = S_GB;
            S_GB:  state_d = cmp_q ? S_CMP : S_EX;
            S_EX:  state_d = S_WB;
            S_CMP: state_d = S_IF1;
            S_WB:  state_d = S_IF1;
            S_LA:  state_d = S_LB;
            S_LB:  state_d = S_LC;
            S_LC:  state_d = S_LM;
            S_LM:  state_d = mem_rdy ? S_LW : S_LM;
            S_LW:  state_d = S_IF1;
            S_SA:  state_d = S_SB;
            S_SB:  state_d = S_SC;
            S_SC:  state_d = S_SD;
            S_SD:  state_d = S_SE;
            S_SE:  state_d = S_SF;
            S_SF:  state_d = mem_rdy ? S_IF1 : S_SF;
`ifdef SEQ_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        reset_pc  = 1'b0;
        load_pc   = 1'b0;
        load_ir   = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = CMD_NONE;
        vsel      = 4'b0000;
        nsel      = 3'b000;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = CMD_READ;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = CMD_READ;
                load_ir  = 1'b1;
            end
            S_UPC: load_pc = 1'b1;
            S_MI: begin
                nsel  = N_RN;
                vsel  = V_IMM;
                write = 1'b1;
            end
            S_MR1: begin
                nsel  = N_RM;
                loadb = 1'b1;
            end
            S_MR2: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_MR3, S_WB: begin
                nsel  = N_RD;
                vsel  = V_C;
                write = 1'b1;
            end
            S_GA, S_LA, S_SA: begin
                nsel  = N_RN;
                loada = 1'b1;
            end
            S_GB: begin
                nsel  = N_RM;
                loadb = 1'b1;
            end
            S_EX:  loadc = 1'b1;
            S_CMP: loads = 1'b1;
            S_LB, S_SB: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_LC, S_SC: load_addr = 1'b1;
            S_LM: mem_cmd = CMD_READ;
            S_LW: begin
                mem_cmd = CMD_READ;
                nsel    = N_RD;
                vsel    = V_MEM;
                write   = 1'b1;
            end
            S_SD: begin
                nsel  = N_RD;
                loadb = 1'b1;
            end
            S_SE: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_SF: mem_cmd = CMD_WRITE;
`ifdef SEQ_HALT_EN
            S_HALT: halted = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer; all outputs are packed into one
// vector and compared against hand-built expected control words.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       mem_rdy;
    logic       reset_pc, load_pc, load_ir, load_addr, addr_sel;
    logic [1:0] mem_cmd;
    logic [3:0] vsel;
    logic [2:0] nsel;
    logic       write, loada, loadb, asel, bsel, loadc, loads, halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op),
        .mem_rdy(mem_rdy), .reset_pc(reset_pc), .load_pc(load_pc),
        .load_ir(load_ir), .load_addr(load_addr), .addr_sel(addr_sel),
        .mem_cmd(mem_cmd), .vsel(vsel), .nsel(nsel), .write(write),
        .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
        .loadc(loadc), .loads(loads), .halted(halted)
    );

    logic [21:0] outs;
    assign outs = {reset_pc, load_pc, load_ir, load_addr, addr_sel,
                   mem_cmd, vsel, nsel, write, loada, loadb, asel,
                   bsel, loadc, loads, halted};

    localparam logic [21:0] RPC = 22'(1) << 21;
    localparam logic [21:0] LPC = 22'(1) << 20;
    localparam logic [21:0] LIR = 22'(1) << 19;
    localparam logic [21:0] LAD = 22'(1) << 18;
    localparam logic [21:0] ASP = 22'(1) << 17;
    localparam logic [21:0] WRC = 22'(1) << 16;
    localparam logic [21:0] RDC = 22'(1) << 15;
    localparam logic [21:0] VMD = 22'(1) << 14;
    localparam logic [21:0] VIM = 22'(1) << 13;
    localparam logic [21:0] VC  = 22'(1) << 11;
    localparam logic [21:0] NRN = 22'(1) << 10;
    localparam logic [21:0] NRD = 22'(1) << 9;
    localparam logic [21:0] NRM = 22'(1) << 8;
    localparam logic [21:0] WRT = 22'(1) << 7;
    localparam logic [21:0] LA  = 22'(1) << 6;
    localparam logic [21:0] LB  = 22'(1) << 5;
    localparam logic [21:0] AS  = 22'(1) << 4;
    localparam logic [21:0] BS  = 22'(1) << 3;
    localparam logic [21:0] LC  = 22'(1) << 2;
    localparam logic [21:0] LS  = 22'(1) << 1;
    localparam logic [21:0] HLT = 22'(1);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [21:0] exp);
        checks++;
        assert (outs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, outs, exp);
        end
    endtask

    // Walks IF1..DECODE with mem_rdy=1; leaves the bench one edge past DECODE.
    task automatic fetch(input string tag);
        chk({tag, "_if1"}, ASP | RDC);
        step();
        chk({tag, "_if2"}, ASP | RDC | LIR);
        step();
        chk({tag, "_upc"}, LPC);
        step();
        chk({tag, "_dec"}, 22'd0);
        step();
    endtask

    initial begin
        reset   = 1'b0;
        mem_rdy = 1'b0;
        opcode  = 3'b000;
        op      = 2'b00;
        step();
        step();
        chk("rst_held", RPC | LPC);
        reset   = 1'b1;
        mem_rdy = 1'b1;
        chk("rst_release", RPC | LPC);
        step();

        // MOV R0,#7
        opcode = 3'b110;
        op     = 2'b10;
        fetch("movi");
        chk("movi_mi", NRN | VIM | WRT);
        step();

        // MOV reg, with an IF1 stall first
        opcode  = 3'b110;
        op      = 2'b00;
        mem_rdy = 1'b0;
        chk("if1_wait", ASP | RDC);
        step();
        mem_rdy = 1'b1;
        fetch("movr");
        chk("movr_mr1", NRM | LB);
        step();
        chk("movr_mr2", AS | LC);
        step();
        chk("movr_mr3", NRD | VC | WRT);
        step();

        // ADD
        opcode = 3'b101;
        op     = 2'b00;
        fetch("add");
        chk("add_ga", NRN | LA);
        step();
        chk("add_gb", NRM | LB);
        step();
        chk("add_ex", LC);
        step();
        chk("add_wb", NRD | VC | WRT);
        step();

        // CMP; op changes after DECODE must not matter
        opcode = 3'b101;
        op     = 2'b01;
        fetch("cmp");
        op = 2'b00;
        chk("cmp_ga", NRN | LA);
        step();
        chk("cmp_gb", NRM | LB);
        step();
        chk("cmp_ex", LS);
        step();

        // LDR with three wait cycles
        opcode = 3'b011;
        op     = 2'b00;
        fetch("ldr");
        chk("ldr_la", NRN | LA);
        step();
        chk("ldr_lb", BS | LC);
        mem_rdy = 1'b0;
        step();
        chk("ldr_lc", LAD);
        step();
        chk("ldr_lm1", RDC);
        step();
        chk("ldr_lm2", RDC);
        step();
        chk("ldr_lm3", RDC);
        step();
        chk("ldr_lm4", RDC);
        mem_rdy = 1'b1;
        step();
        chk("ldr_lw", RDC | NRD | VMD | WRT);
        step();

        // STR interrupted by reset during SF
        opcode = 3'b100;
        op     = 2'b00;
        fetch("str");
        chk("str_sa", NRN | LA);
        step();
        chk("str_sb", BS | LC);
        step();
        chk("str_sc", LAD);
        step();
        chk("str_sd", NRD | LB);
        mem_rdy = 1'b0;
        step();
        chk("str_se", AS | LC);
        step();
        chk("str_sf1", WRC);
        step();
        chk("str_sf2", WRC);
        reset = 1'b0;
        step();
        chk("str_rst", RPC | LPC);
        step();
        chk("str_rst2", RPC | LPC);
        reset   = 1'b1;
        mem_rdy = 1'b1;
        step();
        // Back in IF1: reading, no leftover write

        // Opcode 111
        opcode = 3'b111;
        op     = 2'b00;
        fetch("op7");
`ifdef SEQ_HALT_EN
        for (int i = 0; i < 10; i++) begin
            chk("halt_hold", HLT);
            step();
        end
        reset = 1'b0;
        step();
        chk("halt_rst", RPC | LPC);
        reset = 1'b1;
        step();
`endif
        chk("op7_if1", ASP | RDC);
        step();
        chk("op7_if2", ASP | RDC | LIR);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
